// File: rtl/mlp_forward.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mlp_forward: sequential 2-8-3 MLP forward pass (ReLU hidden layer, argmax, |
// | base-2 softmax) on a single time-multiplexed MAC.                          |
// | Optional feature macro: MLP_FWD_SOFTMAX_EN (EXP/DIV softmax vs hardmax).   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mlp_forward #(
    parameter int DATAWIDTH = 16,
    parameter int FRAC      = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic signed [DATAWIDTH-1:0] inputs     [2],
    input  logic signed [DATAWIDTH-1:0] currW0     [8][2],
    input  logic signed [DATAWIDTH-1:0] currb0     [8],
    input  logic signed [DATAWIDTH-1:0] currW1     [3][8],
    input  logic signed [DATAWIDTH-1:0] currb1     [3],
    output logic                        busy,
    output logic                        done,
    output logic signed [DATAWIDTH-1:0] reluout    [8],
    output logic signed [DATAWIDTH-1:0] logits     [3],
    output logic        [DATAWIDTH-1:0] softmaxout [3],
    output logic        [1:0]           predictedstate
);

    localparam int ACCW = DATAWIDTH + 6;
    localparam int PW   = 2 * DATAWIDTH;
    localparam int CNTW = $clog2(DATAWIDTH);

    localparam logic signed [ACCW-1:0] C_SAT_MAX =
        {{(ACCW-DATAWIDTH+1){1'b0}}, {(DATAWIDTH-1){1'b1}}};
    localparam logic signed [ACCW-1:0] C_SAT_MIN =
        {{(ACCW-DATAWIDTH+1){1'b1}}, {(DATAWIDTH-1){1'b0}}};
    localparam logic signed [DATAWIDTH-1:0] C_POS_MAX = {1'b0, {(DATAWIDTH-1){1'b1}}};
    localparam logic signed [DATAWIDTH-1:0] C_NEG_MIN = {1'b1, {(DATAWIDTH-1){1'b0}}};
    localparam logic [DATAWIDTH-1:0] C_ONE = DATAWIDTH'(1 << FRAC);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_L0     = 3'd1,
        S_L1     = 3'd2,
        S_ARGMAX = 3'd3,
        S_EXP    = 3'd4,
        S_DIV    = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t                      state_q, state_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic signed [DATAWIDTH-1:0] in_q [2], in_d [2];
    logic signed [ACCW-1:0]      acc_q, acc_d;
    logic [2:0]                  nidx_q, nidx_d;
    logic [2:0]                  midx_q, midx_d;
    logic signed [DATAWIDTH-1:0] reluout_q [8], reluout_d [8];
    logic signed [DATAWIDTH-1:0] logits_q [3], logits_d [3];
    logic [DATAWIDTH-1:0]        softmax_q [3], softmax_d [3];
    logic [1:0]                  pred_q, pred_d;
    logic signed [DATAWIDTH-1:0] zmax_q, zmax_d;

    // Shared MAC datapath: operand/bias selection follows the active layer
    logic signed [DATAWIDTH-1:0] w_mac_a, w_mac_b, w_mac_bias;
    logic signed [PW-1:0]        w_prod_full;
    logic signed [ACCW-1:0]      w_prod, w_acc_base, w_acc_sum;
    logic signed [DATAWIDTH-1:0] w_acc_sat, w_relu;

    always_comb begin
        if (state_q == S_L0) begin
            w_mac_a    = in_q[midx_q[0]];
            w_mac_b    = currW0[nidx_q][midx_q[0]];
            w_mac_bias = currb0[nidx_q];
        end else begin
            w_mac_a    = reluout_q[midx_q];
            w_mac_b    = currW1[nidx_q[1:0]][midx_q];
            w_mac_bias = currb1[nidx_q[1:0]];
        end
        w_prod_full = $signed({{DATAWIDTH{w_mac_a[DATAWIDTH-1]}}, w_mac_a})
                    * $signed({{DATAWIDTH{w_mac_b[DATAWIDTH-1]}}, w_mac_b});
        w_prod = ACCW'(w_prod_full >>> FRAC);
        if (midx_q == 3'd0) begin
            w_acc_base = $signed({{(ACCW-DATAWIDTH){w_mac_bias[DATAWIDTH-1]}}, w_mac_bias});
        end else begin
            w_acc_base = acc_q;
        end
        w_acc_sum = w_acc_base + w_prod;
        if (w_acc_sum > C_SAT_MAX) begin
            w_acc_sat = C_POS_MAX;
        end else if (w_acc_sum < C_SAT_MIN) begin
            w_acc_sat = C_NEG_MIN;
        end else begin
            w_acc_sat = w_acc_sum[DATAWIDTH-1:0];
        end
        w_relu = w_acc_sat[DATAWIDTH-1] ? '0 : w_acc_sat;
    end

    // Argmax with strict compare so ties resolve to the lowest index
    logic [1:0]                  w_pred;
    logic signed [DATAWIDTH-1:0] w_zmax;

    always_comb begin
        w_pred = 2'd0;
        w_zmax = logits_q[0];
        if (logits_q[1] > w_zmax) begin
            w_pred = 2'd1;
            w_zmax = logits_q[1];
        end
        if (logits_q[2] > w_zmax) begin
            w_pred = 2'd2;
            w_zmax = logits_q[2];
        end
    end

`ifdef MLP_FWD_SOFTMAX_EN
    logic [DATAWIDTH-1:0]       e_q [3], e_d [3];
    logic [DATAWIDTH-1:0]       sum_q, sum_d;
    logic [DATAWIDTH-1:0]       rem_q, rem_d;
    logic [DATAWIDTH-1:0]       quo_q, quo_d;
    logic [DATAWIDTH-1:0]       hold_q [2], hold_d [2];
    logic [CNTW-1:0]            bit_q, bit_d;
    logic [1:0]                 didx_q, didx_d;

    logic [DATAWIDTH-1:0]       w_e [3];
    logic [DATAWIDTH-1:0]       w_sum;
    logic [DATAWIDTH+FRAC-1:0]  w_num;
    logic [DATAWIDTH-1:0]       w_rem_cur, w_quo_cur, w_rem_nxt, w_quo_nxt;
    logic [DATAWIDTH:0]         w_trial;
    logic                       w_ge;

    genvar gi;
    for (gi = 0; gi < 3; gi++) begin : g_exp
        logic [DATAWIDTH:0] w_dist;
        logic [DATAWIDTH:0] w_k;
        assign w_dist  = {zmax_q[DATAWIDTH-1], zmax_q} - {logits_q[gi][DATAWIDTH-1], logits_q[gi]};
        assign w_k     = w_dist >> FRAC;
        assign w_e[gi] = (w_k > (DATAWIDTH+1)'(FRAC)) ? '0 : (C_ONE >> w_k);
    end

    assign w_sum = w_e[0] + w_e[1] + w_e[2];

    // Restoring divide: the top FRAC bits of the numerator preload the remainder
    // (always below sum since the quotient never exceeds 1.0), the low DATAWIDTH
    // bits are shifted in one per cycle.
    always_comb begin
        w_num = {e_q[didx_q], {FRAC{1'b0}}};
        if (bit_q == '0) begin
            w_rem_cur = DATAWIDTH'(w_num >> DATAWIDTH);
            w_quo_cur = w_num[DATAWIDTH-1:0];
        end else begin
            w_rem_cur = rem_q;
            w_quo_cur = quo_q;
        end
        w_trial   = {w_rem_cur, w_quo_cur[DATAWIDTH-1]};
        w_ge      = (w_trial >= {1'b0, sum_q});
        w_rem_nxt = w_ge ? DATAWIDTH'(w_trial - {1'b0, sum_q}) : w_trial[DATAWIDTH-1:0];
        w_quo_nxt = {w_quo_cur[DATAWIDTH-2:0], w_ge};
    end
`endif

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        in_d      = in_q;
        acc_d     = acc_q;
        nidx_d    = nidx_q;
        midx_d    = midx_q;
        reluout_d = reluout_q;
        logits_d  = logits_q;
        softmax_d = softmax_q;
        pred_d    = pred_q;
        zmax_d    = zmax_q;
`ifdef MLP_FWD_SOFTMAX_EN
        e_d       = e_q;
        sum_d     = sum_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        hold_d    = hold_q;
        bit_d     = bit_q;
        didx_d    = didx_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    in_d    = inputs;
                    busy_d  = 1'b1;
                    nidx_d  = 3'd0;
                    midx_d  = 3'd0;
                    state_d = S_L0;
                end
            end
            S_L0: begin
                acc_d = w_acc_sum;
                if (midx_q == 3'd1) begin
                    reluout_d[nidx_q] = w_relu;
                    midx_d            = 3'd0;
                    nidx_d            = (nidx_q == 3'd7) ? 3'd0 : nidx_q + 3'd1;
                    if (nidx_q == 3'd7) begin
                        state_d = S_L1;
                    end
                end else begin
                    midx_d = midx_q + 3'd1;
                end
            end
            S_L1: begin
                acc_d = w_acc_sum;
                if (midx_q == 3'd7) begin
                    logits_d[nidx_q[1:0]] = w_acc_sat;
                    midx_d                = 3'd0;
                    nidx_d                = (nidx_q == 3'd2) ? 3'd0 : nidx_q + 3'd1;
                    if (nidx_q == 3'd2) begin
                        state_d = S_ARGMAX;
                    end
                end else begin
                    midx_d = midx_q + 3'd1;
                end
            end
            S_ARGMAX: begin
                zmax_d = w_zmax;
                pred_d = w_pred;
`ifdef MLP_FWD_SOFTMAX_EN
                state_d = S_EXP;
`else
                for (int i = 0; i < 3; i++) begin
                    softmax_d[i] = (w_pred == 2'(i)) ? C_ONE : '0;
                end
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_DONE;
`endif
            end
`ifdef MLP_FWD_SOFTMAX_EN
            S_EXP: begin
                e_d     = w_e;
                sum_d   = w_sum;
                bit_d   = '0;
                didx_d  = 2'd0;
                state_d = S_DIV;
            end
            S_DIV: begin
                rem_d = w_rem_nxt;
                quo_d = w_quo_nxt;
                if (bit_q == CNTW'(DATAWIDTH-1)) begin
                    bit_d = '0;
                    if (didx_q == 2'd2) begin
                        softmax_d[0] = hold_q[0];
                        softmax_d[1] = hold_q[1];
                        softmax_d[2] = w_quo_nxt;
                        busy_d       = 1'b0;
                        done_d       = 1'b1;
                        state_d      = S_DONE;
                    end else begin
                        hold_d[didx_q[0]] = w_quo_nxt;
                        didx_d            = didx_q + 2'd1;
                    end
                end else begin
                    bit_d = bit_q + 1'b1;
                end
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            acc_q   <= '0;
            nidx_q  <= '0;
            midx_q  <= '0;
            pred_q  <= '0;
            zmax_q  <= '0;
            for (int i = 0; i < 2; i++) in_q[i]      <= '0;
            for (int i = 0; i < 8; i++) reluout_q[i] <= '0;
            for (int i = 0; i < 3; i++) logits_q[i]  <= '0;
            for (int i = 0; i < 3; i++) softmax_q[i] <= '0;
`ifdef MLP_FWD_SOFTMAX_EN
            for (int i = 0; i < 3; i++) e_q[i]    <= '0;
            for (int i = 0; i < 2; i++) hold_q[i] <= '0;
            sum_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            bit_q  <= '0;
            didx_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            acc_q   <= acc_d;
            nidx_q  <= nidx_d;
            midx_q  <= midx_d;
            pred_q  <= pred_d;
            zmax_q  <= zmax_d;
            for (int i = 0; i < 2; i++) in_q[i]      <= in_d[i];
            for (int i = 0; i < 8; i++) reluout_q[i] <= reluout_d[i];
            for (int i = 0; i < 3; i++) logits_q[i]  <= logits_d[i];
            for (int i = 0; i < 3; i++) softmax_q[i] <= softmax_d[i];
`ifdef MLP_FWD_SOFTMAX_EN
            for (int i = 0; i < 3; i++) e_q[i]    <= e_d[i];
            for (int i = 0; i < 2; i++) hold_q[i] <= hold_d[i];
            sum_q  <= sum_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            bit_q  <= bit_d;
            didx_q <= didx_d;
`endif
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign reluout        = reluout_q;
    assign logits         = logits_q;
    assign softmaxout     = softmax_q;
    assign predictedstate = pred_q;

endmodule
`default_nettype wire

// File: tb/tb_mlp_forward.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mlp_forward: directed table-driven bench for mlp_forward, with          |
// | sequences for reset abort, start-while-busy and start-in-DONE.             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mlp_forward;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic signed [15:0] inputs  [2];
    logic signed [15:0] W0      [8][2];
    logic signed [15:0] b0      [8];
    logic signed [15:0] W1      [3][8];
    logic signed [15:0] b1      [3];
    logic               busy;
    logic               done;
    logic signed [15:0] reluout [8];
    logic signed [15:0] logits  [3];
    logic        [15:0] softmaxout [3];
    logic        [1:0]  predictedstate;

    mlp_forward #(.DATAWIDTH(16), .FRAC(10)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .inputs         (inputs),
        .currW0         (W0),
        .currb0         (b0),
        .currW1         (W1),
        .currb1         (b1),
        .busy           (busy),
        .done           (done),
        .reluout        (reluout),
        .logits         (logits),
        .softmaxout     (softmaxout),
        .predictedstate (predictedstate)
    );

    always #5 clk = ~clk;

`ifdef MLP_FWD_SOFTMAX_EN
    localparam int EXP_LAT = 91;
`else
    localparam int EXP_LAT = 42;
`endif

    typedef struct {
        string                 name;
        logic [1:0][15:0]      x;
        logic [7:0][1:0][15:0] w0;
        logic [7:0][15:0]      b0;
        logic [2:0][7:0][15:0] w1;
        logic [2:0][15:0]      b1;
        logic [7:0][15:0]      relu;
        logic [2:0][15:0]      logit;
        logic [1:0]            pred;
        logic [2:0][15:0]      sm;
    } vec_t;

    vec_t vecs [6];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   done_cnt = 0;

    always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h)", nm, act, act, exp, exp);
        end
    endtask

    function automatic vec_t blank(input string nm);
        vec_t v;
        v.name  = nm;
        v.x     = '0;
        v.w0    = '0;
        v.b0    = '0;
        v.w1    = '0;
        v.b1    = '0;
        v.relu  = '0;
        v.logit = '0;
        v.pred  = '0;
        v.sm    = '0;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        for (int j = 0; j < 2; j++) inputs[j] = v.x[j];
        for (int n = 0; n < 8; n++) begin
            b0[n] = v.b0[n];
            for (int j = 0; j < 2; j++) W0[n][j] = v.w0[n][j];
        end
        for (int k = 0; k < 3; k++) begin
            b1[k] = v.b1[k];
            for (int j = 0; j < 8; j++) W1[k][j] = v.w1[k][j];
        end
    endtask

    // lat counts rising edges with the accepting edge as 1; a second start
    // pulse is driven in cycle dup_at when non-zero.
    task automatic run_pass(input string nm, input int dup_at, output int lat);
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 1;
        chk({nm, ".busy_on"}, 16'(busy), 16'd1);
        while (done !== 1'b1 && lat < 300) begin
            start = (lat == dup_at);
            @(posedge clk);
            #1;
            start = 1'b0;
            lat++;
        end
        chk({nm, ".latency"}, 16'(lat), 16'(EXP_LAT));
        chk({nm, ".busy_at_done"}, 16'(busy), 16'd0);
    endtask

    task automatic check_results(input vec_t v);
        logic [15:0] sm_exp;
        for (int i = 0; i < 8; i++)
            chk($sformatf("%s.relu%0d", v.name, i), reluout[i], v.relu[i]);
        for (int i = 0; i < 3; i++)
            chk($sformatf("%s.logit%0d", v.name, i), logits[i], v.logit[i]);
        chk({v.name, ".pred"}, {14'd0, predictedstate}, {14'd0, v.pred});
        for (int i = 0; i < 3; i++) begin
`ifdef MLP_FWD_SOFTMAX_EN
            sm_exp = v.sm[i];
`else
            sm_exp = (v.pred == 2'(i)) ? 16'd1024 : 16'd0;
`endif
            chk($sformatf("%s.sm%0d", v.name, i), softmaxout[i], sm_exp);
        end
    endtask

    initial begin
        int lat;
        int dc0;

        vecs[0] = blank("zeros");
        vecs[0].sm = {16'd341, 16'd341, 16'd341};

        vecs[1] = blank("single");
        vecs[1].x[0] = 16'd2048;
        vecs[1].w0[0][0] = 16'd1024;
        vecs[1].w1[2][0] = 16'd1024;
        vecs[1].relu[0] = 16'd2048;
        vecs[1].logit[2] = 16'd2048;
        vecs[1].pred = 2'd2;
        vecs[1].sm = {16'd682, 16'd170, 16'd170};

        vecs[2] = vecs[1];
        vecs[2].name = "bias_neg";
        for (int n = 0; n < 8; n++) vecs[2].b0[n] = 16'(-4096);
        vecs[2].relu = '0;
        vecs[2].logit = '0;
        vecs[2].pred = 2'd0;
        vecs[2].sm = {16'd341, 16'd341, 16'd341};

        vecs[3] = blank("saturate");
        vecs[3].x = {16'd32767, 16'd32767};
        for (int n = 0; n < 8; n++) begin
            vecs[3].w0[n] = {16'd32767, 16'd32767};
            vecs[3].relu[n] = 16'd32767;
            vecs[3].w1[1][n] = 16'd1024;
            vecs[3].w1[2][n] = 16'd1024;
        end
        vecs[3].w1[0][0] = 16'h8000;
        vecs[3].b1[1] = 16'(-1024);
        vecs[3].b1[2] = 16'd1024;
        vecs[3].logit = {16'd32767, 16'd32767, 16'h8000};
        vecs[3].pred = 2'd1;
        vecs[3].sm = {16'd512, 16'd512, 16'd0};

        vecs[4] = blank("mixed");
        vecs[4].x = {16'(-1024), 16'd1024};
        vecs[4].w0[0][0] = 16'd1024;
        vecs[4].w0[1][1] = 16'(-1024);
        vecs[4].w0[2][0] = 16'(-1024);
        vecs[4].w1[0][0] = 16'(-16384);
        vecs[4].w1[1][1] = 16'd2048;
        vecs[4].b1[2] = 16'd512;
        vecs[4].relu[0] = 16'd1024;
        vecs[4].relu[1] = 16'd1024;
        vecs[4].logit = {16'd512, 16'd2048, 16'(-16384)};
        vecs[4].pred = 2'd1;
        vecs[4].sm = {16'd341, 16'd682, 16'd0};

        vecs[5] = blank("tie12");
        vecs[5].x[0] = 16'd1024;
        vecs[5].w0[0][0] = 16'd1024;
        vecs[5].b0[3] = 16'd512;
        vecs[5].w1[1][0] = 16'd1024;
        vecs[5].w1[2][0] = 16'd1024;
        vecs[5].b1[0] = 16'(-2048);
        vecs[5].relu[0] = 16'd1024;
        vecs[5].relu[3] = 16'd512;
        vecs[5].logit = {16'd1024, 16'd1024, 16'(-2048)};
        vecs[5].pred = 2'd1;
        vecs[5].sm = {16'd481, 16'd481, 16'd60};

        rst = 1'b1;
        start = 1'b0;
        apply(vecs[0]);
        repeat (3) @(posedge clk);
        #1;
        chk("reset.busy", 16'(busy), 16'd0);
        chk("reset.done", 16'(done), 16'd0);
        chk("reset.pred", {14'd0, predictedstate}, 16'd0);
        chk("reset.relu0", reluout[0], 16'd0);
        chk("reset.logit2", logits[2], 16'd0);
        chk("reset.sm0", softmaxout[0], 16'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 6; v++) begin
            apply(vecs[v]);
            run_pass(vecs[v].name, 0, lat);
            check_results(vecs[v]);
        end

        // start during the DONE cycle must be ignored
        dc0 = done_cnt;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("done_start.busy", 16'(busy), 16'd0);
        repeat (100) @(posedge clk);
        #1;
        chk("done_start.busy_later", 16'(busy), 16'd0);
        chk("done_start.done_count", 16'(done_cnt - dc0), 16'd1);

        // reset asserted in L1 aborts the pass
        apply(vecs[1]);
        dc0 = done_cnt;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (24) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort.busy", 16'(busy), 16'd0);
        chk("abort.relu0", reluout[0], 16'd0);
        chk("abort.relu3", reluout[3], 16'd0);
        chk("abort.logit1", logits[1], 16'd0);
        chk("abort.sm1", softmaxout[1], 16'd0);
        chk("abort.pred", {14'd0, predictedstate}, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        chk("abort.no_done", 16'(done_cnt - dc0), 16'd0);

        // fresh pass with a redundant start while busy
        dc0 = done_cnt;
        run_pass("rerun", 10, lat);
        check_results(vecs[1]);
        repeat (120) @(posedge clk);
        #1;
        chk("rerun.one_done", 16'(done_cnt - dc0), 16'd1);
        chk("rerun.idle_busy", 16'(busy), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
